// File: rtl/spike_buf_pkg.sv
// -----------------------------------------------------------------------------
// spike_buf_pkg
// Shared types and constants for the input spike buffer:
//   - state_e      : control FSM states (RESET / RUN / SWAP)
//   - AER_AXON_LSB : bit position of the axon index inside an AER packet
//   - aer_axon_msb : top bit of the axon index for a given index width
// -----------------------------------------------------------------------------
package spike_buf_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_SWAP  = 2'd2
  } state_e;

  // The axon index occupies the low bits of the packet; upper bits are ignored.
  localparam int AER_AXON_LSB = 0;

  function automatic int aer_axon_msb(input int axon_w);
    return AER_AXON_LSB + axon_w - 1;
  endfunction

endpackage

// File: rtl/spike_bank.sv
// -----------------------------------------------------------------------------
// spike_bank
// One NUM_AXONS-bit spike bank: one bit per axon.
// Ports:
//   clk_i, rst_i     : clock, async active-high reset (clears every bit)
//   set_en_i         : set the bit at set_idx_i on the next edge
//   set_idx_i        : index to set; also drives set_hit_o
//   set_hit_o        : current value of the bit at set_idx_i (duplicate detect)
//   clr_i            : clear all bits on the next edge (a set in the same edge
//                      still lands, though the top never asserts both)
//   rd0_idx_i/rd0_o  : combinational read port 0
//   rd1_idx_i/rd1_o  : combinational read port 1
// Indices >= NUM_AXONS read as 0 and are never stored.
// -----------------------------------------------------------------------------
module spike_bank #(
  parameter int NUM_AXONS = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_idx_i,
  output logic              set_hit_o,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] rd0_idx_i,
  output logic              rd0_o,
  input  logic [ADDR_W-1:0] rd1_idx_i,
  output logic              rd1_o
);

  // Full index space; bits above NUM_AXONS-1 are tied to 0 so that
  // out-of-range reads return 0 without a separate range compare.
  localparam int DEPTH = 1 << ADDR_W;

  logic [NUM_AXONS-1:0] bits_q, bits_d;
  logic [DEPTH-1:0]     bits_ext;
  logic [DEPTH-1:0]     set_mask_ext;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    bits_ext     = DEPTH'(bits_q);
    set_mask_ext = DEPTH'(1) << set_idx_i;
    bits_d       = bits_q;
    if (clr_i)    bits_d = '0;
    if (set_en_i) bits_d = bits_d | NUM_AXONS'(set_mask_ext);
  end

  assign set_hit_o = bits_ext[set_idx_i];
  assign rd0_o     = bits_ext[rd0_idx_i];
  assign rd1_o     = bits_ext[rd1_idx_i];

  // NOTE: the bank is a flop vector, not a RAM macro, so resetting every bit
  // is legal and makes both banks start empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from pre-edge values.
    if (rst_i) bits_q <= '0;
    else       bits_q <= bits_d;
  end

endmodule

// File: rtl/in_spike_buffer.sv
// -----------------------------------------------------------------------------
// in_spike_buffer
// Double-banked axon spike buffer. AER packets from the router set one bit per
// axon in the write bank during a timestep; tick_i swaps banks (one SWAP
// cycle) so the data path reads the last completed step through two
// registered read ports.
// Ports:
//   clk_i, rst_i            : clock, async active-high reset
//   aer_data_i/valid/ready  : AER packet input handshake (ready only in RUN)
//   tick_i                  : timestep-boundary pulse
//   rcl_axonAddr_i/_inSpike_o : recall read port (1-cycle latency)
//   lrn_axonAddr_i/_inSpike_o : learn read port (1-cycle latency)
//   spkCnt_o                : distinct spikes of the last completed step
//   dupSpk_o / addrErr_o    : sticky duplicate / bad-index flags
//   errClr_i                : clears both sticky flags (wins over a set)
// -----------------------------------------------------------------------------
module in_spike_buffer
  import spike_buf_pkg::*;
#(
  parameter int NUM_AXONS          = 256,
  parameter int AXON_CNT_BIT_WIDTH = 8,
  parameter int AER_BIT_WIDTH      = 32,
  parameter int SPK_CNT_BIT_WIDTH  = 9
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [AER_BIT_WIDTH-1:0]      aer_data_i,
  input  logic                          aer_valid_i,
  output logic                          aer_ready_o,
  input  logic                          tick_i,
  input  logic [AXON_CNT_BIT_WIDTH-1:0] rcl_axonAddr_i,
  input  logic [AXON_CNT_BIT_WIDTH-1:0] lrn_axonAddr_i,
  output logic                          rcl_inSpike_o,
  output logic                          lrn_inSpike_o,
  output logic [SPK_CNT_BIT_WIDTH-1:0]  spkCnt_o,
  output logic                          dupSpk_o,
  output logic                          addrErr_o,
  input  logic                          errClr_i
);

  localparam int AXON_MSB = aer_axon_msb(AXON_CNT_BIT_WIDTH);

  state_e                         state_q, state_d;
  logic                           wr_sel_q, wr_sel_d;
  logic                           ready_q, ready_d;
  logic                           rcl_q, rcl_d;
  logic                           lrn_q, lrn_d;
  logic [SPK_CNT_BIT_WIDTH-1:0]   step_cnt_q, step_cnt_d;
  logic [SPK_CNT_BIT_WIDTH-1:0]   spk_cnt_q, spk_cnt_d;
  logic                           dup_q, dup_d;
  logic                           addr_err_q, addr_err_d;

  logic [AXON_CNT_BIT_WIDTH-1:0]  aer_idx;
  logic                           idx_in_range;
  logic                           accept, store, swap;
  logic                           wr_hit, new_spk, dup_evt, err_evt;
  logic                           b0_hit, b1_hit;
  logic                           b0_rcl, b1_rcl, b0_lrn, b1_lrn;

  assign aer_idx = aer_data_i[AXON_MSB:AER_AXON_LSB];

  generate
    if (AER_BIT_WIDTH > AXON_MSB + 1) begin : g_aer_upper
      logic aer_upper_unused;
      assign aer_upper_unused = ^aer_data_i[AER_BIT_WIDTH-1:AXON_MSB+1];
    end
  endgenerate

  assign idx_in_range = 32'(aer_idx) < NUM_AXONS;
  assign accept       = aer_valid_i & ready_q;
  assign store        = accept & idx_in_range;
  assign swap         = (state_q == ST_SWAP);

  // Duplicate detection looks at the bank currently being written.
  assign wr_hit  = wr_sel_q ? b1_hit : b0_hit;
  assign new_spk = store & ~wr_hit;
  assign dup_evt = store & wr_hit;
  assign err_evt = accept & ~idx_in_range;

  // The bank that becomes the write bank after the swap is the outgoing read
  // bank; it is cleared on the same edge that toggles wr_sel.
  spike_bank #(
    .NUM_AXONS (NUM_AXONS),
    .ADDR_W    (AXON_CNT_BIT_WIDTH)
  ) u_bank0 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .set_en_i  (store & ~wr_sel_q),
    .set_idx_i (aer_idx),
    .set_hit_o (b0_hit),
    .clr_i     (swap & wr_sel_q),
    .rd0_idx_i (rcl_axonAddr_i),
    .rd0_o     (b0_rcl),
    .rd1_idx_i (lrn_axonAddr_i),
    .rd1_o     (b0_lrn)
  );

  spike_bank #(
    .NUM_AXONS (NUM_AXONS),
    .ADDR_W    (AXON_CNT_BIT_WIDTH)
  ) u_bank1 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .set_en_i  (store & wr_sel_q),
    .set_idx_i (aer_idx),
    .set_hit_o (b1_hit),
    .clr_i     (swap & ~wr_sel_q),
    .rd0_idx_i (rcl_axonAddr_i),
    .rd0_o     (b1_rcl),
    .rd1_idx_i (lrn_axonAddr_i),
    .rd1_o     (b1_lrn)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN:   if (tick_i) state_d = ST_SWAP;
      ST_SWAP:  state_d = ST_RUN;   // a tick seen here is dropped
      default:  state_d = ST_RESET;
    endcase

    // Ready is registered from the next state so it is glitch-free and
    // drops in exactly the SWAP cycle.
    ready_d  = (state_d == ST_RUN);
    wr_sel_d = swap ? ~wr_sel_q : wr_sel_q;

    // An accept on the tick cycle is counted before the SWAP cycle copies
    // the counter, so it belongs to the ending step.
    step_cnt_d = step_cnt_q;
    if (swap)
      step_cnt_d = '0;
    else if (new_spk && (step_cnt_q != '1))
      step_cnt_d = step_cnt_q + SPK_CNT_BIT_WIDTH'(1);

    spk_cnt_d = swap ? step_cnt_q : spk_cnt_q;

    dup_d      = errClr_i ? 1'b0 : (dup_q | dup_evt);
    addr_err_d = errClr_i ? 1'b0 : (addr_err_q | err_evt);

    // Read bank is the one not selected for writing; during SWAP wr_sel has
    // not toggled yet, so the ports still see the outgoing read bank.
    rcl_d = wr_sel_q ? b0_rcl : b1_rcl;
    lrn_d = wr_sel_q ? b0_lrn : b1_lrn;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_RESET;
      wr_sel_q   <= 1'b0;
      ready_q    <= 1'b0;
      rcl_q      <= 1'b0;
      lrn_q      <= 1'b0;
      step_cnt_q <= '0;
      spk_cnt_q  <= '0;
      dup_q      <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_sel_q   <= wr_sel_d;
      ready_q    <= ready_d;
      rcl_q      <= rcl_d;
      lrn_q      <= lrn_d;
      step_cnt_q <= step_cnt_d;
      spk_cnt_q  <= spk_cnt_d;
      dup_q      <= dup_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign aer_ready_o   = ready_q;
  assign rcl_inSpike_o = rcl_q;
  assign lrn_inSpike_o = lrn_q;
  assign spkCnt_o      = spk_cnt_q;
  assign dupSpk_o      = dup_q;
  assign addrErr_o     = addr_err_q;

endmodule
